// File: rtl/dae_decoder_sched.sv
// dae_decoder_sched
// Time-multiplexed sequencer for the DAE decoder stage. A single shared
// multiply / shift / bias / saturate / ReLU unit evaluates one neuron per
// cycle: two hidden neurons (H0, H1), then four output neurons (O0..O3).
// Coefficients live in a 12-entry bank written through the cfg port.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   feature pair handshake (ready only in IDLE)
//   feature0/feature1   signed 8-bit encoder features
//   cfg_we/addr/data    coefficient write port (accepted only in IDLE)
//   cfg_ready           high in IDLE; writes while low are dropped
//   out_valid/out_ready reconstruction handshake (valid in DONE)
//   output0..output3    signed 8-bit denoised samples
//   busy                high in any state other than IDLE
module dae_decoder_sched #(
    parameter int FRAC     = 4,
    parameter bit RELU_OUT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic signed [7:0] feature0,
    input  logic signed [7:0] feature1,
    input  logic              cfg_we,
    input  logic        [3:0] cfg_addr,
    input  logic signed [7:0] cfg_data,
    output logic              cfg_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic signed [7:0] output0,
    output logic signed [7:0] output1,
    output logic signed [7:0] output2,
    output logic signed [7:0] output3,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE, H0, H1, O0, O1, O2, O3, DONE
    } state_t;

    state_t state_q, state_d;

    // Bank map: 0..1 w3, 2..3 b3, 4..7 w4, 8..11 b4.
    logic signed [7:0] coef_q [0:11];
    logic signed [7:0] f0_q, f1_q, h0_q, h1_q;
    logic signed [7:0] out_q [0:3];

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = H0;
            H0:      state_d = H1;
            H1:      state_d = O0;
            O0:      state_d = O1;
            O1:      state_d = O2;
            O2:      state_d = O3;
            O3:      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        cfg_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
    end

    // ---------------- shared neuron unit ----------------
    logic signed [7:0]  nx, nw, nb;
    logic               nrelu;
    logic signed [15:0] prod, prod_sh;
    logic signed [16:0] sum;
    logic signed [7:0]  sat, neuron;

    always_comb begin
        nx    = '0;
        nw    = '0;
        nb    = '0;
        nrelu = 1'b1;
        case (state_q)
            H0: begin nx = f0_q; nw = coef_q[0]; nb = coef_q[2];  end
            H1: begin nx = f1_q; nw = coef_q[1]; nb = coef_q[3];  end
            O0: begin nx = h0_q; nw = coef_q[4]; nb = coef_q[8];  nrelu = RELU_OUT; end
            O1: begin nx = h0_q; nw = coef_q[5]; nb = coef_q[9];  nrelu = RELU_OUT; end
            O2: begin nx = h1_q; nw = coef_q[6]; nb = coef_q[10]; nrelu = RELU_OUT; end
            O3: begin nx = h1_q; nw = coef_q[7]; nb = coef_q[11]; nrelu = RELU_OUT; end
            default: ;
        endcase
    end

    always_comb begin
        prod    = nx * nw;
        prod_sh = prod >>> FRAC;
        // 17 bits holds any shifted product plus bias without wrap.
        sum     = {prod_sh[15], prod_sh} + {{9{nb[7]}}, nb};
        if (sum > 17'sd127)       sat = 8'sd127;
        else if (sum < -17'sd128) sat = -8'sd128;
        else                      sat = sum[7:0];
        neuron  = (nrelu && sat[7]) ? 8'sd0 : sat;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 12; i++) coef_q[i] <= '0;
            for (int i = 0; i < 4; i++)  out_q[i]  <= '0;
            f0_q <= '0;
            f1_q <= '0;
            h0_q <= '0;
            h1_q <= '0;
        end else begin
            // A write in the accepting IDLE cycle lands before H0 reads it.
            if (cfg_we && state_q == IDLE && cfg_addr < 4'd12)
                coef_q[cfg_addr] <= cfg_data;
            if (state_q == IDLE && in_valid) begin
                f0_q <= feature0;
                f1_q <= feature1;
            end
            case (state_q)
                H0: h0_q     <= neuron;
                H1: h1_q     <= neuron;
                O0: out_q[0] <= neuron;
                O1: out_q[1] <= neuron;
                O2: out_q[2] <= neuron;
                O3: out_q[3] <= neuron;
                default: ;
            endcase
        end
    end

    assign output0 = out_q[0];
    assign output1 = out_q[1];
    assign output2 = out_q[2];
    assign output3 = out_q[3];

endmodule

// File: tb/tb_dae_decoder_sched.sv
module tb_dae_decoder_sched;

    localparam int FRAC = 4;

    logic clk = 1'b0;
    logic rst, in_valid, cfg_we, out_ready;
    logic signed [7:0] feature0, feature1, cfg_data;
    logic [3:0] cfg_addr;

    // u_r: RELU_OUT=1, u_l: RELU_OUT=0; both see identical stimulus.
    logic in_ready_r, cfg_ready_r, out_valid_r, busy_r;
    logic in_ready_l, cfg_ready_l, out_valid_l, busy_l;
    logic signed [7:0] or0, or1, or2, or3, ol0, ol1, ol2, ol3;

    int checks = 0;
    int errors = 0;
    int cm [0:15];

    always #5 clk = ~clk;

    dae_decoder_sched #(.FRAC(FRAC), .RELU_OUT(1'b1)) u_r (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
        .feature0(feature0), .feature1(feature1), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready_r),
        .out_valid(out_valid_r), .out_ready(out_ready),
        .output0(or0), .output1(or1), .output2(or2), .output3(or3), .busy(busy_r));

    dae_decoder_sched #(.FRAC(FRAC), .RELU_OUT(1'b0)) u_l (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
        .feature0(feature0), .feature1(feature1), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready_l),
        .out_valid(out_valid_l), .out_ready(out_ready),
        .output0(ol0), .output1(ol1), .output2(ol2), .output3(ol3), .busy(busy_l));

    typedef struct {
        int f0;
        int f1;
        int e0, e1, e2, e3;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference neuron: floor-divide by 2^FRAC, add bias, clamp, optional ReLU.
    function automatic int neuron(int x, int w, int b, bit relu);
        int s;
        s = ((x * w) >>> FRAC) + b;
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        if (relu && s < 0) s = 0;
        return s;
    endfunction

    task automatic model(input int f0, input int f1, input bit relu, output int o [4]);
        int h0, h1;
        h0 = neuron(f0, cm[0], cm[2], 1'b1);
        h1 = neuron(f1, cm[1], cm[3], 1'b1);
        o[0] = neuron(h0, cm[4], cm[8], relu);
        o[1] = neuron(h0, cm[5], cm[9], relu);
        o[2] = neuron(h1, cm[6], cm[10], relu);
        o[3] = neuron(h1, cm[7], cm[11], relu);
    endtask

    task automatic clear_model;
        for (int i = 0; i < 16; i++) cm[i] = 0;
    endtask

    // Only called while the DUT is idle, so the write is accepted.
    task automatic cfg_write(input int a, input int d);
        cfg_we = 1'b1; cfg_addr = 4'(a); cfg_data = 8'(d);
        tick;
        cfg_we = 1'b0;
        if (a < 12) cm[a] = d;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid_r && n < 20) begin
            tick;
            n++;
        end
    endtask

    task automatic chk_outs(input string tag, input int er [4], input int el [4]);
        chk({tag, " r.o0"}, int'(or0), er[0]);
        chk({tag, " r.o1"}, int'(or1), er[1]);
        chk({tag, " r.o2"}, int'(or2), er[2]);
        chk({tag, " r.o3"}, int'(or3), er[3]);
        chk({tag, " l.o0"}, int'(ol0), el[0]);
        chk({tag, " l.o1"}, int'(ol1), el[1]);
        chk({tag, " l.o2"}, int'(ol2), el[2]);
        chk({tag, " l.o3"}, int'(ol3), el[3]);
    endtask

    // Accept one frame, check 6-cycle latency and outputs, then drain it.
    task automatic run_frame(input string tag, input int f0, input int f1,
                             input int er [4], input int el [4]);
        int n;
        in_valid = 1'b1; feature0 = 8'(f0); feature1 = 8'(f1);
        tick;
        in_valid = 1'b0;
        chk({tag, " busy"}, int'(busy_r), 1);
        wait_done(n);
        chk({tag, " latency"}, n, 6);
        chk({tag, " l.valid"}, int'(out_valid_l), 1);
        chk_outs(tag, er, el);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk({tag, " in_ready"}, int'(in_ready_r), 1);
    endtask

    task automatic load_basic;
        cfg_write(0, 16); cfg_write(1, 16); cfg_write(2, 0); cfg_write(3, 0);
        cfg_write(4, 16); cfg_write(5, 32); cfg_write(6, 16); cfg_write(7, 48);
        cfg_write(8, 3);  cfg_write(9, 0);  cfg_write(10, 0); cfg_write(11, 0);
    endtask

    task automatic do_reset_mid;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        clear_model();
    endtask

    initial begin
        vec_t tbl [6];
        int er [4];
        int el [4];
        int z [4];
        int n;

        tbl[0] = '{10, 5, 13, 20, 5, 15};
        tbl[1] = '{0, 0, 3, 0, 0, 0};
        tbl[2] = '{-20, 7, 3, 0, 7, 21};
        tbl[3] = '{127, 127, 127, 127, 127, 127};
        tbl[4] = '{50, -1, 53, 100, 0, 0};
        tbl[5] = '{60, 40, 63, 120, 40, 120};
        z = '{0, 0, 0, 0};

        rst = 1'b1; in_valid = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        out_ready = 1'b0; feature0 = 8'sd9; feature1 = 8'sd9;
        clear_model();

        // 1: reset with in_valid held high
        tick;
        chk("rst busy c1", int'(busy_r), 0);
        tick;
        chk("rst busy c2", int'(busy_r), 0);
        chk("rst out_valid", int'(out_valid_r), 0);
        chk("rst in_ready", int'(in_ready_r), 1);
        chk("rst cfg_ready", int'(cfg_ready_r), 1);
        chk_outs("rst", z, z);
        in_valid = 1'b0;
        rst = 1'b0;
        tick;
        chk("post-rst idle", int'(busy_r), 0);

        // 2: table-driven frames with the basic coefficient set
        load_basic();
        for (int i = 0; i < 6; i++) begin
            er = '{tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3};
            run_frame($sformatf("tbl%0d", i), tbl[i].f0, tbl[i].f1, er, er);
        end

        // 3: hidden saturation
        cfg_write(0, 127); cfg_write(4, 16); cfg_write(8, 0);
        model(100, 5, 1'b1, er);
        model(100, 5, 1'b0, el);
        chk("sat model o0", er[0], 127);
        run_frame("sat", 100, 5, er, el);

        // 4: hidden ReLU, then negative bias with and without output ReLU
        cfg_write(0, -16);
        model(10, 5, 1'b1, er);
        model(10, 5, 1'b0, el);
        run_frame("hrelu", 10, 5, er, el);
        chk("hrelu o0", int'(or0), 0);
        cfg_write(8, -5);
        model(10, 5, 1'b1, er);
        model(10, 5, 1'b0, el);
        run_frame("negb", 10, 5, er, el);
        chk("negb lin o0", int'(ol0), -5);
        chk("negb relu o0", int'(or0), 0);

        // 5: backpressure with in_valid held
        load_basic();
        model(10, 5, 1'b1, er);
        in_valid = 1'b1; feature0 = 8'sd10; feature1 = 8'sd5;
        tick;
        feature0 = 8'sd60; feature1 = 8'sd40;
        wait_done(n);
        chk("bp latency", n, 6);
        for (int c = 0; c < 10; c++) begin
            chk("bp valid", int'(out_valid_r), 1);
            chk("bp in_ready", int'(in_ready_r), 0);
            chk("bp cfg_ready", int'(cfg_ready_r), 0);
            chk("bp o0", int'(or0), er[0]);
            chk("bp o3", int'(or3), er[3]);
            tick;
        end
        chk_outs("bp hold", er, er);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("bp idle", int'(in_ready_r), 1);
        tick;
        in_valid = 1'b0;
        chk("bp 2nd accept", int'(busy_r), 1);
        model(60, 40, 1'b1, er);
        wait_done(n);
        chk("bp2 latency", n, 6);
        chk_outs("bp2", er, er);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;

        // 6a: cfg write during H1 is dropped
        model(10, 5, 1'b1, er);
        in_valid = 1'b1; feature0 = 8'sd10; feature1 = 8'sd5;
        tick;
        in_valid = 1'b0;
        tick;
        cfg_we = 1'b1; cfg_addr = 4'd4; cfg_data = 8'sd99;
        tick;
        cfg_we = 1'b0;
        wait_done(n);
        chk("drop latency", n, 4);
        chk_outs("drop", er, er);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;

        // 6b: reset during O1
        in_valid = 1'b1; feature0 = 8'sd10; feature1 = 8'sd5;
        tick;
        in_valid = 1'b0;
        tick; tick; tick;
        do_reset_mid();
        chk("mid-rst busy", int'(busy_r), 0);
        chk("mid-rst valid", int'(out_valid_r), 0);
        chk("mid-rst in_ready", int'(in_ready_r), 1);
        chk_outs("mid-rst", z, z);
        model(10, 5, 1'b1, er);
        run_frame("zero coef", 10, 5, er, er);
        load_basic();
        er = '{13, 20, 5, 15};
        run_frame("after rst", 10, 5, er, er);

        // Randomized frames against the reference model
        for (int t = 0; t < 25; t++) begin
            int f0, f1;
            for (int a = 0; a < 12; a++)
                cfg_write(a, int'($signed(8'($urandom_range(0, 255)))));
            f0 = int'($signed(8'($urandom_range(0, 255))));
            f1 = int'($signed(8'($urandom_range(0, 255))));
            model(f0, f1, 1'b1, er);
            model(f0, f1, 1'b0, el);
            run_frame($sformatf("rnd%0d", t), f0, f1, er, el);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
